// File: rtl/c17_lock_pkg.sv
// Shared types and constants for the key-locked c17 pipeline.
// No logic here: FSM state encoding, per-lane key width and the unlocking key value.
package c17_lock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam int KEY_W = 4;

  // {k3,k2,k1,k0}; restores the original c17 function for a lane
  localparam logic [KEY_W-1:0] CORRECT_KEY = 4'b0100;

endpackage

// File: rtl/c17_locked_core.sv
// Single-lane key-locked c17 netlist, purely combinational (0 cycles).
// No flow control; the caller registers inputs and outputs.
module c17_locked_core
  import c17_lock_pkg::*;
(
  input  logic             pi1,
  input  logic             pi2,
  input  logic             pi3,
  input  logic             pi6,
  input  logic             pi7,
  input  logic [KEY_W-1:0] key,
  output logic             po22,
  output logic             po23
);

  logic n0, n1, n2, n3, n4, n5, n6, n7, n8;

  assign n0   = ~pi7;
  assign n1   = ~(key[0] ^ n0);
  assign n2   = ~(pi1 & pi3);
  assign n3   = ~(pi3 & pi6);
  assign n4   = n1 & n3;
  assign n5   = n3 & pi2;
  assign n6   = key[2] ^ n4;
  assign n7   = ~(n5 ^ key[1]);
  assign po22 = ~(n2 & n7);
  assign n8   = ~(n7 & n6);
  assign po23 = n8 ^ key[3];

endmodule

// File: rtl/c17_locked_pipe.sv
// LANES key-locked c17 lanes between input/output registers; serial key load with atomic commit.
// Latency 2 cycles; in_ready drops while a key is loading, in-flight vectors finish with the old key.
module c17_locked_pipe
  import c17_lock_pkg::*;
#(
  parameter int LANES    = 4,
  parameter bit GATE_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] pi1,
  input  logic [LANES-1:0] pi2,
  input  logic [LANES-1:0] pi3,
  input  logic [LANES-1:0] pi6,
  input  logic [LANES-1:0] pi7,
  input  logic             key_start,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_done,
  output logic             locked,
  output logic             out_valid,
  output logic [LANES-1:0] po22,
  output logic [LANES-1:0] po23
);

  localparam int KW = KEY_W * LANES;
  localparam int CW = $clog2(KW) + 1;

  state_t          state;
  logic [KW-1:0]   key_reg;
  logic [KW-1:0]   shift_reg;
  logic [KW-1:0]   shift_nxt;
  logic [CW-1:0]   bit_cnt;
  logic            accept_bit;
  logic            last_bit;

  assign in_ready   = (state != LOAD);
  assign accept_bit = (state == LOAD) && key_valid && !key_start;
  assign last_bit   = (bit_cnt == CW'(KW - 1));

  // bit_cnt is always below KW while loading, so the truncated index is exact
  always_comb begin
    shift_nxt = shift_reg;
    shift_nxt[bit_cnt[CW-2:0]] = key_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_reg   <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      locked    <= 1'b1;
      key_done  <= 1'b0;
    end else begin
      key_done <= 1'b0;
      if (key_start) begin
        state     <= LOAD;
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (accept_bit) begin
        shift_reg <= shift_nxt;
        bit_cnt   <= bit_cnt + 1'b1;
        if (last_bit) begin
          key_reg  <= shift_nxt;
          key_done <= 1'b1;
          locked   <= 1'b0;
          state    <= ARMED;
        end
      end
    end
  end

  // Stage 1: input capture
  logic             s1_vld;
  logic [LANES-1:0] s1_pi1, s1_pi2, s1_pi3, s1_pi6, s1_pi7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_pi1 <= '0;
      s1_pi2 <= '0;
      s1_pi3 <= '0;
      s1_pi6 <= '0;
      s1_pi7 <= '0;
    end else begin
      s1_vld <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_pi1 <= pi1;
        s1_pi2 <= pi2;
        s1_pi3 <= pi3;
        s1_pi6 <= pi6;
        s1_pi7 <= pi7;
      end
    end
  end

  logic [LANES-1:0] c22, c23;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    c17_locked_core u_core (
      .pi1  (s1_pi1[l]),
      .pi2  (s1_pi2[l]),
      .pi3  (s1_pi3[l]),
      .pi6  (s1_pi6[l]),
      .pi7  (s1_pi7[l]),
      .key  (key_reg[KEY_W*l +: KEY_W]),
      .po22 (c22[l]),
      .po23 (c23[l])
    );
  end

  // Stage 2: outputs are zeroed while locked if gating is enabled
  logic gate;
  assign gate = GATE_OUT && locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      po22      <= '0;
      po23      <= '0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        po22 <= gate ? '0 : c22;
        po23 <= gate ? '0 : c23;
      end
    end
  end

endmodule

// File: tb/tb_c17_locked_pipe.sv
// Directed bench for c17_locked_pipe: gated (GATE_OUT=1) and ungated (GATE_OUT=0) copies share stimulus.
// Covers reset, key load/restart/commit, LOAD backpressure, mid-load reset and all 32 vectors per lane.
module tb_c17_locked_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] pi1, pi2, pi3, pi6, pi7;
  logic       key_start, key_bit, key_valid;

  logic       in_ready, key_done, locked, out_valid;
  logic [3:0] po22, po23;
  logic       u_in_ready, u_key_done, u_locked, u_out_valid;
  logic [3:0] u_po22, u_po23;

  int n_chk  = 0;
  int n_pass = 0;
  int kd_cnt = 0;

  c17_locked_pipe #(.LANES(4), .GATE_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pi1(pi1), .pi2(pi2), .pi3(pi3), .pi6(pi6), .pi7(pi7),
    .key_start(key_start), .key_bit(key_bit), .key_valid(key_valid),
    .key_done(key_done), .locked(locked), .out_valid(out_valid),
    .po22(po22), .po23(po23)
  );

  c17_locked_pipe #(.LANES(4), .GATE_OUT(1'b0)) dut_ungated (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .pi1(pi1), .pi2(pi2), .pi3(pi3), .pi6(pi6), .pi7(pi7),
    .key_start(key_start), .key_bit(key_bit), .key_valid(key_valid),
    .key_done(u_key_done), .locked(u_locked), .out_valid(u_out_valid),
    .po22(u_po22), .po23(u_po23)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (key_done) kd_cnt++;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Original (unlocked) c17 netlist; v = {pi1,pi2,pi3,pi6,pi7}, returns {po22,po23}
  function automatic logic [1:0] c17ref(input logic [4:0] v);
    logic n10, n11, n16, n19;
    n10 = ~(v[4] & v[2]);
    n11 = ~(v[2] & v[1]);
    n16 = ~(v[3] & n11);
    n19 = ~(n11 & v[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  // lv[5*l +: 5] = {pi1,pi2,pi3,pi6,pi7} for lane l
  task automatic apply(input logic [19:0] lv);
    for (int l = 0; l < 4; l++) begin
      pi1[l] = lv[5*l+4];
      pi2[l] = lv[5*l+3];
      pi3[l] = lv[5*l+2];
      pi6[l] = lv[5*l+1];
      pi7[l] = lv[5*l];
    end
  endtask

  task automatic start_load();
    key_start = 1'b1;
    step();
    key_start = 1'b0;
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_bit   = v[i];
      step();
    end
    key_valid = 1'b0;
    key_bit   = 1'b0;
  endtask

  // One all-ones vector through the pipe; leaves the bench just after its output edge
  task automatic send_ones();
    apply(20'hFFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  logic [19:0] cur, prev;
  logic [3:0]  e22, e23;
  logic [1:0]  r;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; key_start = 1'b0; key_bit = 1'b0; key_valid = 1'b0;
    apply(20'h0);
    cur = '0; prev = '0;
    step();
    step();
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_locked",   16'(locked),   16'h1);
    chk("rst_out_vld",  16'(out_valid), 16'h0);
    chk("rst_key_done", 16'(key_done), 16'h0);
    chk("rst_po",       {8'h0, po22, po23}, 16'h0);
    rst_n = 1'b1;
    step();

    // Locked, gated: zeros but valid; ungated copy shows wrong-key corruption with key 0
    apply(20'hFFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_lat1_vld", 16'(out_valid), 16'h0);
    step();
    chk("t1_out_vld",  16'(out_valid), 16'h1);
    chk("t1_po_gated", {8'h0, po22, po23}, 16'h0);
    chk("t1_locked",   16'(locked), 16'h1);
    chk("t3_po_key0",  {8'h0, u_po22, u_po23}, 16'h00FF);
    step();
    chk("t1_vld_drop", 16'(out_valid), 16'h0);

    // Load correct key in every lane; key_done one cycle after the 16th bit
    start_load();
    chk("t2_ready_low", 16'(in_ready), 16'h0);
    shift_bits(16'h4444, 15);
    chk("t2_kd_early", 16'(key_done), 16'h0);
    chk("t2_locked_ld", 16'(locked), 16'h1);
    key_valid = 1'b1; key_bit = 1'b0;
    step();
    key_valid = 1'b0;
    chk("t2_kd_pulse", 16'(key_done), 16'h1);
    chk("t2_unlocked", 16'(locked), 16'h0);
    chk("t2_ready_hi", 16'(in_ready), 16'h1);
    step();
    chk("t2_kd_end", 16'(key_done), 16'h0);
    chk("t2_kd_cnt", 16'(kd_cnt), 16'd1);
    send_ones();
    chk("t2_po", {8'h0, po22, po23}, 16'h00F0);

    // Restart after 7 ones, then a full key
    start_load();
    shift_bits(16'hFFFF, 7);
    chk("t4_still_locked_out", 16'(locked), 16'h0);
    start_load();
    shift_bits(16'h4444, 16);
    step();
    chk("t4_kd_cnt", 16'(kd_cnt), 16'd2);

    // All 32 vectors per lane, lanes offset so each cycle differs across lanes
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) begin
        for (int l = 0; l < 4; l++) cur[5*l +: 5] = 5'((i + 7*l) % 32);
        apply(cur);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i > 0) begin
        for (int l = 0; l < 4; l++) begin
          r = c17ref(prev[5*l +: 5]);
          e22[l] = r[1];
          e23[l] = r[0];
        end
        chk("exh_vld",   16'(out_valid), 16'h1);
        chk("exh_po",    {8'h0, po22, po23}, {8'h0, e22, e23});
        chk("exh_po_ug", {8'h0, u_po22, u_po23}, {8'h0, e22, e23});
      end
      prev = cur;
    end

    // In-flight vectors finish with the old key; in_valid ignored during LOAD
    apply(20'hFFFFF);
    in_valid = 1'b1;
    step();
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    chk("t5_ready_low", 16'(in_ready), 16'h0);
    chk("t5_a_vld", 16'(out_valid), 16'h1);
    chk("t5_a_po",  {8'h0, po22, po23}, 16'h00F0);
    step();
    chk("t5_b_vld", 16'(out_valid), 16'h1);
    chk("t5_b_po",  {8'h0, po22, po23}, 16'h00F0);
    step();
    chk("t5_c_ignored", 16'(out_valid), 16'h0);
    step();
    chk("t5_c_ignored2", 16'(out_valid), 16'h0);
    in_valid = 1'b0;
    shift_bits(16'h0000, 16);
    chk("t5_kd_pulse", 16'(key_done), 16'h1);
    step();
    chk("t5_kd_cnt", 16'(kd_cnt), 16'd3);
    send_ones();
    chk("t5_newkey_po", {8'h0, po22, po23}, 16'h00FF);

    // Reset in the middle of a load
    start_load();
    shift_bits(16'h4444, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_locked",   16'(locked), 16'h1);
    chk("t6_in_ready", 16'(in_ready), 16'h1);
    chk("t6_out_vld",  16'(out_valid), 16'h0);
    chk("t6_po",       {8'h0, po22, po23}, 16'h0);
    step();
    rst_n = 1'b1;
    shift_bits(16'hFFFF, 7);
    step();
    chk("t6_kd_cnt", 16'(kd_cnt), 16'd3);
    chk("t6_locked_after", 16'(locked), 16'h1);
    send_ones();
    chk("t6_po_gated", {8'h0, po22, po23}, 16'h0);
    chk("t6_po_key0",  {8'h0, u_po22, u_po23}, 16'h00FF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
